equiv_vector_sequencer: RTL and testbench
=========================================

Name: equiv_vector_sequencer

Overview:
- Sequences exhaustive stimulus through two combinational circuits-under-test (golden and revised netlist).
- Both circuits share one input vector; the block compares their outputs and reports equivalence, first mismatch vector and mismatch count.
- Sits in the gate-level equivalence-checking harness, above two instantiated TopLevel-style netlists.
- Replaces hand-written vector benches.

Parameters:
- N_IN, 2, input width of both circuits; sweep covers 2^N_IN vectors (1..16).
- N_OUT, 2, output width of both circuits.
- SETTLE, 1, cycles the vector is held before sampling (>=1; 0 is illegal, flag at elaboration).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin sweep; honoured only in IDLE or DONE.
- stop_on_first  input  1  sampled with start; 1 = end sweep at first mismatch.
- vec  output  N_IN  stimulus driven to both circuits.
- out_a  input  N_OUT  golden circuit outputs.
- out_b  input  N_OUT  revised circuit outputs.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until next start or reset.
- equiv  output  1  valid when done; 1 = no mismatch seen.
- mismatch_vec  output  N_IN  first vector with out_a != out_b; 0 if none.
- mismatch_cnt  output  N_IN+1  number of mismatching vectors; cannot overflow.

Behaviour:
- Reset (async, immediate): state IDLE; vec=0, busy=0, done=0, equiv=0, mismatch_vec=0, mismatch_cnt=0; settle counter and stop flag cleared.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE, start=1 at edge:
  - vec<=0, mismatch_cnt<=0, mismatch_vec<=0, done<=0, busy<=1.
  - Latch stop_on_first; settle counter<=0; go DRIVE.
- DRIVE:
  - settle counter increments each edge.
  - When counter==SETTLE-1, go SAMPLE, so DRIVE lasts exactly SETTLE cycles.
- SAMPLE (one cycle): compare out_a vs out_b combinationally at the edge.
  - On mismatch: mismatch_cnt<=mismatch_cnt+1; if this is the first mismatch, mismatch_vec<=vec.
  - If vec==all-ones, or (mismatch and latched stop flag): go DONE.
  - Otherwise vec<=vec+1, counter<=0, go DRIVE.
- DONE:
  - busy=0, done=1, equiv=(mismatch_cnt==0).
  - vec holds its last value.
- Latency: with start accepted at edge k, done is high after edge k + V*(SETTLE+1).
  - V = 2^N_IN for a full sweep.
  - V = index of the stopping vector + 1 for an early stop.
- vec wrap: never increments past all-ones; the last vector terminates the sweep.
- start while busy: ignored. stop_on_first changes mid-sweep: ignored.
- start in same cycle as DONE entry: DONE is entered; start is honoured on a later cycle.
- Reset mid-sweep: immediate return to IDLE with reset values; partial results discarded.
- All outputs are registered; no combinational path from out_a/out_b to any output.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, DRIVE, SAMPLE, DONE);
  - a function computing vector count 2^N_IN;
  - the SETTLE minimum constant.
- One natural sub-module: equiv_settle_counter, a loadable down/up counter with terminal flag, reused by future multi-cycle harness controllers.
- The comparator stays inline.

Test Plan:
- Identical circuits (out_b=out_a=~vec), N_IN=2, SETTLE=1, start pulse -> vec steps 0,1,2,3, two cycles each; done after 8 cycles; equiv=1, mismatch_cnt=0, mismatch_vec=0.
- out_b differs only at vec=2, stop_on_first=0 -> full sweep, done after 8 cycles; equiv=0, mismatch_cnt=1, mismatch_vec=2.
- out_b differs at vec=1 and 3, stop_on_first=1 -> done after 4 cycles, vec=1; mismatch_cnt=1, mismatch_vec=1.
- SETTLE=3, N_IN=3, all vectors mismatch -> done after 32 cycles; mismatch_cnt=8 (no overflow), mismatch_vec=0.
- rst asserted during DRIVE of vec=2 -> all outputs at reset values in the same cycle; a later start runs a clean full sweep.
- start pulsed while busy, and again in DONE -> first ignored, no change to the sweep; second restarts with counters cleared.

Source files
------------

// File: rtl/equiv_vector_sequencer_pkg.sv
// Shared types and helpers for the gate-level equivalence vector sequencer.
package equiv_vector_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int unsigned SETTLE_MIN = 32'd1;

    function automatic int unsigned vec_count(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/equiv_settle_counter.sv
// Loadable up/down counter with a terminal-value match flag.
module equiv_settle_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         up_i,
    input  logic [W-1:0] term_val_i,
    output logic [W-1:0] count_o,
    output logic         term_o
);

    logic [W-1:0] count_q;

    // Count register: load has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i) begin
            count_q <= up_i ? (count_q + W'(1)) : (count_q - W'(1));
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == term_val_i);

endmodule

// File: rtl/equiv_vector_sequencer.sv
// Exhaustive stimulus sweep over two combinational netlists, comparing their
// outputs and reporting equivalence, first mismatching vector and mismatch count.
module equiv_vector_sequencer
    import equiv_vector_sequencer_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop_on_first,
    output logic [N_IN-1:0]  vec,
    input  logic [N_OUT-1:0] out_a,
    input  logic [N_OUT-1:0] out_b,
    output logic             busy,
    output logic             done,
    output logic             equiv,
    output logic [N_IN-1:0]  mismatch_vec,
    output logic [N_IN:0]    mismatch_cnt
);

    if (SETTLE < SETTLE_MIN) begin : g_bad_settle
        $error("equiv_vector_sequencer: SETTLE must be at least 1");
    end

    localparam int unsigned NUM_VEC = vec_count(N_IN);
    localparam logic [N_IN-1:0] VEC_LAST = N_IN'(NUM_VEC - 1);
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_TERM = CW'(SETTLE - 1);

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN-1:0] mvec_q, mvec_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            equiv_q, equiv_d;
    logic            stop_q, stop_d;
    logic            mismatch_s;
    logic            cnt_load_s;
    logic            cnt_en_s;
    logic            settle_term_s;
    logic [CW-1:0]   settle_cnt_s;

    equiv_settle_counter #(.W(CW)) u_settle (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load_s),
        .load_val_i ({CW{1'b0}}),
        .en_i       (cnt_en_s),
        .up_i       (1'b1),
        .term_val_i (SETTLE_TERM),
        .count_o    (settle_cnt_s),
        .term_o     (settle_term_s)
    );

    // Next-state and result update for the sweep controller.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        mvec_d     = mvec_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        equiv_d    = equiv_q;
        stop_d     = stop_q;
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;
        mismatch_s = (out_a != out_b);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    vec_d      = '0;
                    mvec_d     = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    equiv_d    = 1'b0;
                    stop_d     = stop_on_first;
                    cnt_load_s = 1'b1;
                    state_d    = ST_DRIVE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DRIVE: begin
                cnt_en_s = 1'b1;
                if (settle_term_s) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch_s) begin
                    cnt_d = cnt_q + (N_IN+1)'(1);
                    if (cnt_q == '0) begin
                        mvec_d = vec_q;
                    end else begin
                        mvec_d = mvec_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
                // The last vector always ends the sweep, so vec never wraps.
                if ((vec_q == VEC_LAST) || (mismatch_s && stop_q)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    equiv_d = (cnt_d == '0);
                    state_d = ST_DONE;
                end else begin
                    vec_d      = vec_q + N_IN'(1);
                    cnt_load_s = 1'b1;
                    state_d    = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            mvec_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            equiv_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mvec_q  <= mvec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            equiv_q <= equiv_d;
            stop_q  <= stop_d;
        end
    end

    assign vec          = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign equiv        = equiv_q;
    assign mismatch_vec = mvec_q;
    assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_equiv_vector_sequencer.sv
// Randomized scoreboard bench for equiv_vector_sequencer against a sweep-level model.
module tb_equiv_vector_sequencer;

    localparam int N_IN    = 3;
    localparam int N_OUT   = 2;
    localparam int SETTLE  = 3;
    localparam int NV      = 1 << N_IN;
    localparam int CYC_PER = SETTLE + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop_on_first;
    logic [N_IN-1:0]  vec;
    logic [N_OUT-1:0] out_a;
    logic [N_OUT-1:0] out_b;
    logic             busy;
    logic             done;
    logic             equiv;
    logic [N_IN-1:0]  mismatch_vec;
    logic [N_IN:0]    mismatch_cnt;
    logic [NV-1:0]    cur_mask;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int start_cyc;
        int equiv;
        int mvec;
        int cnt;
        int last_vec;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   mon_j;
    bit   done_prev = 1'b0;

    equiv_vector_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop_on_first (stop_on_first),
        .vec           (vec),
        .out_a         (out_a),
        .out_b         (out_b),
        .busy          (busy),
        .done          (done),
        .equiv         (equiv),
        .mismatch_vec  (mismatch_vec),
        .mismatch_cnt  (mismatch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Golden and revised circuits: revised flips a bit on vectors selected by cur_mask.
    always_comb begin
        out_a = ~vec[1:0] ^ {1'b0, vec[2]};
        out_b = cur_mask[vec] ? (out_a ^ 2'b10) : out_a;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [NV-1:0] m, input bit stp);
        exp_t e;
        e.start_cyc = 0;
        e.cnt       = 0;
        e.mvec      = 0;
        e.last_vec  = NV - 1;
        for (int v = 0; v < NV; v++) begin
            if (m[v]) begin
                if (e.cnt == 0) e.mvec = v;
                e.cnt++;
                if (stp) begin
                    e.last_vec = v;
                    break;
                end
            end
        end
        e.equiv = (e.cnt == 0) ? 1 : 0;
        return e;
    endfunction

    // Monitor: tracks the sweep trajectory and scores each completed sweep.
    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (sb.size() > 0 && !done) begin
                mon_e = sb[0];
                mon_j = cyc - mon_e.start_cyc;
                check("busy_during_sweep", busy, 1);
                check("vec_step", vec, mon_j / CYC_PER);
            end
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("latency", cyc - mon_e.start_cyc, (mon_e.last_vec + 1) * CYC_PER);
                    check("equiv", equiv, mon_e.equiv);
                    check("mismatch_vec", mismatch_vec, mon_e.mvec);
                    check("mismatch_cnt", mismatch_cnt, mon_e.cnt);
                    check("final_vec", vec, mon_e.last_vec);
                    check("busy_at_done", busy, 0);
                end
            end
            done_prev = done;
        end
    end

    task automatic issue_start(input logic [NV-1:0] m, input bit stp);
        exp_t e;
        cur_mask = m;
        @(negedge clk);
        start = 1'b1;
        stop_on_first = stp;
        @(negedge clk);
        start = 1'b0;
        stop_on_first = ~stp;
        e = model(m, stp);
        e.start_cyc = cyc;
        sb.push_back(e);
        check("start_clears_done", done, 0);
        check("start_clears_cnt", mismatch_cnt, 0);
        check("start_sets_busy", busy, 1);
    endtask

    task automatic run(input logic [NV-1:0] m, input bit stp, input bit poke);
        int t;
        issue_start(m, stp);
        if (poke && model(m, stp).last_vec >= 3) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            stop_on_first = ~stp;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) begin
            check("sweep_timeout", 0, 1);
            sb.delete();
        end
        repeat (2) @(negedge clk);
        check("done_held", done, 1);
    endtask

    task automatic reset_mid_sweep();
        int t;
        issue_start(NV'($urandom), 1'b0);
        t = 0;
        while (vec != 3'd2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reached_vec2", vec, 2);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        sb.delete();
        check("rst_vec", vec, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_equiv", equiv, 0);
        check("rst_mvec", mismatch_vec, 0);
        check("rst_cnt", mismatch_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop_on_first = 1'b0;
        cur_mask = '0;
        repeat (2) @(negedge clk);
        check("reset_vec", vec, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_equiv", equiv, 0);
        check("reset_mvec", mismatch_vec, 0);
        check("reset_cnt", mismatch_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        run(8'h00, 1'b0, 1'b0);
        run(8'h04, 1'b0, 1'b1);
        run(8'h0A, 1'b1, 1'b0);
        run(8'hFF, 1'b0, 1'b0);
        run(8'hFF, 1'b1, 1'b0);
        run(8'h80, 1'b1, 1'b1);
        reset_mid_sweep();
        run(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            run(NV'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
